// File: rtl/rsa_probe_pkg.sv
// Shared definitions for the RSA timing probe: FSM encoding and the packed
// layout of a latency record {cycles, message, match, sat}.
package rsa_probe_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int OFF_SAT   = 0;
   localparam int OFF_MATCH = 1;
   localparam int OFF_MSG   = 2;

   function automatic int rec_w(input int cnt_w, input int width);
      return cnt_w + width + 2;
   endfunction

   function automatic int off_cycles(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/rsa_probe_fifo.sv
// Synchronous circular FIFO with registered read port, occupancy count and
// drop-on-full; a push into a full FIFO is only accepted alongside a pop.
module rsa_probe_fifo #(
   parameter int REC_W = 26,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [REC_W-1:0]           wr_data,
   input  logic                       pop,
   output logic                       rd_valid,
   output logic [REC_W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && full && !pop_ok;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= pop_ok;
         if (pop_ok) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rsa_timing_probe.sv
// Measures RSA decryption latency from launch to finish, checks the decrypted
// message against the applied plaintext and queues one record per run.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for start; done is ignored here
//   ST_RUN  | counting cycles until done; start is ignored here
import rsa_probe_pkg::*;

module rsa_timing_probe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [WIDTH-1:0]       m_ref,
   input  logic                   done,
   input  logic [WIDTH-1:0]       m_decrypted,
   input  logic                   rd_en,
   output logic                   rd_valid,
   output logic [CNT_W-1:0]       rd_cycles,
   output logic [WIDTH-1:0]       rd_msg,
   output logic                   rd_match,
   output logic                   rd_sat,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full,
   output logic                   overflow
);

   localparam int REC_W   = rec_w(CNT_W, WIDTH);
   localparam int OFF_CYC = off_cycles(WIDTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             sat_q, sat_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic             push;
   logic             drop;
   logic [REC_W-1:0] rec;
   logic [REC_W-1:0] rd_rec;

   // Saturating increment; a record whose cycle field is all-ones is flagged sat.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign rec     = {cnt_inc, m_decrypted, (m_decrypted == ref_q),
                     (sat_q || (cnt_inc == '1))};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         ref_q    <= '0;
         overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         ref_q   <= ref_d;
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      ref_d   = ref_q;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ref_d   = m_ref;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (done) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == '1) begin
                  sat_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_RUN);

   rsa_probe_fifo #(
      .REC_W (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .wr_data  (rec),
      .pop      (rd_en),
      .rd_valid (rd_valid),
      .rd_data  (rd_rec),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .drop     (drop)
   );

   assign rd_cycles = rd_rec[OFF_CYC +: CNT_W];
   assign rd_msg    = rd_rec[OFF_MSG +: WIDTH];
   assign rd_match  = rd_rec[OFF_MATCH];
   assign rd_sat    = rd_rec[OFF_SAT];

endmodule

// File: tb/tb_rsa_timing_probe.sv
// Directed bench for rsa_timing_probe: a default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_rsa_timing_probe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] m_ref = '0;
   logic       done = 1'b0;
   logic [7:0] m_decrypted = '0;
   logic       rd_en = 1'b0;

   logic        rd_valid, rd_match, rd_sat, busy, empty, full, overflow;
   logic [15:0] rd_cycles;
   logic [7:0]  rd_msg;
   logic [3:0]  count;

   logic       s_rd_valid, s_rd_match, s_rd_sat, s_busy, s_empty, s_full, s_overflow;
   logic [3:0] s_rd_cycles;
   logic [7:0] s_rd_msg;
   logic [3:0] s_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rsa_timing_probe #(.WIDTH(8), .CNT_W(16), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .m_ref(m_ref), .done(done),
      .m_decrypted(m_decrypted), .rd_en(rd_en), .rd_valid(rd_valid),
      .rd_cycles(rd_cycles), .rd_msg(rd_msg), .rd_match(rd_match),
      .rd_sat(rd_sat), .busy(busy), .count(count), .empty(empty),
      .full(full), .overflow(overflow)
   );

   rsa_timing_probe #(.WIDTH(8), .CNT_W(4), .DEPTH(8)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .m_ref(m_ref), .done(done),
      .m_decrypted(m_decrypted), .rd_en(rd_en), .rd_valid(s_rd_valid),
      .rd_cycles(s_rd_cycles), .rd_msg(s_rd_msg), .rd_match(s_rd_match),
      .rd_sat(s_rd_sat), .busy(s_busy), .count(s_count), .empty(s_empty),
      .full(s_full), .overflow(s_overflow)
   );

   typedef struct {
      logic [7:0]  ref_v;
      logic [7:0]  dec_v;
      int          k;
      logic [15:0] exp_cycles;
      logic        exp_match;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // start sampled at edge t, done sampled at edge t+k
   task automatic run(input logic [7:0] r, input logic [7:0] d, input int k);
      start = 1'b1;
      m_ref = r;
      tick();
      start = 1'b0;
      repeat (k - 1) tick();
      done = 1'b1;
      m_decrypted = d;
      tick();
      done = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'h2A, 8'h2A, 37,  16'd37,  1'b1};
      vecs[1] = '{8'h2A, 8'h2B, 1,   16'd1,   1'b0};
      vecs[2] = '{8'h00, 8'h00, 2,   16'd2,   1'b1};
      vecs[3] = '{8'hFF, 8'h7F, 5,   16'd5,   1'b0};
      vecs[4] = '{8'h55, 8'h55, 100, 16'd100, 1'b1};

      do_reset();
      chk("reset_rd_valid", 32'(rd_valid), 32'd0);
      chk("reset_rd_cycles", 32'(rd_cycles), 32'd0);
      chk("reset_rd_msg", 32'(rd_msg), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);

      for (int i = 0; i < 5; i++) begin
         run(vecs[i].ref_v, vecs[i].dec_v, vecs[i].k);
         chk($sformatf("v%0d_busy_low", i), 32'(busy), 32'd0);
         chk($sformatf("v%0d_count", i), 32'(count), 32'd1);
         pop();
         chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'd1);
         chk($sformatf("v%0d_cycles", i), 32'(rd_cycles), 32'(vecs[i].exp_cycles));
         chk($sformatf("v%0d_msg", i), 32'(rd_msg), 32'(vecs[i].dec_v));
         chk($sformatf("v%0d_match", i), 32'(rd_match), 32'(vecs[i].exp_match));
         chk($sformatf("v%0d_sat", i), 32'(rd_sat), 32'd0);
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'd1);
         tick();
         chk($sformatf("v%0d_valid_pulse", i), 32'(rd_valid), 32'd0);
         chk($sformatf("v%0d_hold_cycles", i), 32'(rd_cycles), 32'(vecs[i].exp_cycles));
      end

      // Overflow: nine runs, no pops.
      do_reset();
      for (int i = 1; i <= 9; i++) run(8'(i), 8'(i), i + 2);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         pop();
         chk($sformatf("ovf_pop%0d_valid", i), 32'(rd_valid), 32'd1);
         chk($sformatf("ovf_pop%0d_cycles", i), 32'(rd_cycles), 32'(i + 2));
         chk($sformatf("ovf_pop%0d_msg", i), 32'(rd_msg), 32'(i));
      end
      chk("ovf_empty", 32'(empty), 32'd1);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      pop();
      chk("empty_pop_valid", 32'(rd_valid), 32'd0);

      // Push and pop together while full.
      do_reset();
      for (int i = 1; i <= 8; i++) run(8'(i), 8'(i), i + 2);
      chk("pp_full", 32'(full), 32'd1);
      start = 1'b1;
      m_ref = 8'h99;
      tick();
      start = 1'b0;
      repeat (2) tick();
      done = 1'b1;
      m_decrypted = 8'h99;
      rd_en = 1'b1;
      tick();
      done = 1'b0;
      rd_en = 1'b0;
      chk("pp_rd_valid", 32'(rd_valid), 32'd1);
      chk("pp_rd_cycles", 32'(rd_cycles), 32'd3);
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_overflow", 32'(overflow), 32'd0);
      for (int i = 2; i <= 8; i++) pop();
      chk("pp_prev_last", 32'(rd_msg), 32'd8);
      pop();
      chk("pp_new_cycles", 32'(rd_cycles), 32'd3);
      chk("pp_new_msg", 32'(rd_msg), 32'h99);
      chk("pp_new_match", 32'(rd_match), 32'd1);
      chk("pp_empty", 32'(empty), 32'd1);

      // Push and pop together while empty: pop ignored, push lands.
      do_reset();
      start = 1'b1;
      m_ref = 8'h11;
      tick();
      start = 1'b0;
      done = 1'b1;
      m_decrypted = 8'h11;
      rd_en = 1'b1;
      tick();
      done = 1'b0;
      rd_en = 1'b0;
      chk("pe_rd_valid", 32'(rd_valid), 32'd0);
      chk("pe_count", 32'(count), 32'd1);

      // Ignored events.
      do_reset();
      done = 1'b1;
      m_decrypted = 8'h33;
      tick();
      done = 1'b0;
      chk("ign_done_idle_count", 32'(count), 32'd0);
      chk("ign_done_idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      done = 1'b1;
      m_ref = 8'h44;
      tick();
      done = 1'b0;
      chk("ign_start_done_idle_busy", 32'(busy), 32'd1);
      chk("ign_start_done_idle_count", 32'(count), 32'd0);
      m_ref = 8'h00;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      done = 1'b1;
      m_decrypted = 8'h44;
      tick();
      start = 1'b0;
      done = 1'b0;
      chk("ign_count", 32'(count), 32'd1);
      chk("ign_busy", 32'(busy), 32'd0);
      tick();
      chk("ign_busy_after", 32'(busy), 32'd0);
      chk("ign_count_after", 32'(count), 32'd1);
      pop();
      chk("ign_cycles", 32'(rd_cycles), 32'd3);
      chk("ign_match", 32'(rd_match), 32'd1);

      // Saturation on the CNT_W=4 instance.
      do_reset();
      run(8'h5A, 8'h5A, 40);
      pop();
      chk("sat_valid", 32'(s_rd_valid), 32'd1);
      chk("sat_cycles", 32'(s_rd_cycles), 32'd15);
      chk("sat_flag", 32'(s_rd_sat), 32'd1);
      chk("nosat_wide_cycles", 32'(rd_cycles), 32'd40);
      chk("nosat_wide_flag", 32'(rd_sat), 32'd0);
      run(8'h5A, 8'h5A, 14);
      pop();
      chk("sat_edge_cycles", 32'(s_rd_cycles), 32'd14);
      chk("sat_edge_flag", 32'(s_rd_sat), 32'd0);

      // Reset in the middle of a run.
      do_reset();
      start = 1'b1;
      m_ref = 8'h77;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("mid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      done = 1'b1;
      m_decrypted = 8'h77;
      tick();
      done = 1'b0;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_empty", 32'(empty), 32'd1);
      pop();
      chk("mid_rd_valid", 32'(rd_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
